axis_byte_packer: RTL
=====================

AXIS_BYTE_PACKER -- requirements
Module: axis_byte_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 256: AXIS tdata width in bits, multiple of 8.
REQ-002 SHALL have parameter TUSER_WIDTH, default 128: AXIS tuser width in bits.
REQ-003 SHALL derive KEEP_WIDTH = DATA_WIDTH/8 as a localparam.
REQ-004 SHALL have port axis_aclk, input, 1: the single clock; all logic on its rising edge.
REQ-005 SHALL have port axis_resetn, input, 1: reset, synchronous and active-low.
REQ-006 SHALL have port s_axis_tdata/tkeep/tuser/tlast/tvalid, input, DATA_WIDTH/KEEP_WIDTH/TUSER_WIDTH/1/1: sparse input stream.
REQ-007 SHALL have port s_axis_tready, output, 1: input accept.
REQ-008 SHALL have port m_axis_tdata/tkeep/tuser/tlast/tvalid, output, DATA_WIDTH/KEEP_WIDTH/TUSER_WIDTH/1/1: packed output stream.
REQ-009 SHALL have port m_axis_tready, input, 1: output accept.
REQ-010 SHALL have port keep_err, output, 1: sticky flag for non-contiguous input tkeep.

Function
REQ-011 SHALL define input byte count n as the index of the lowest zero bit of s_axis_tkeep (KEEP_WIDTH if all ones); bytes above the first zero are ignored.
REQ-012 SHALL set keep_err when an accepted beat has any tkeep bit set above index n; cleared only by reset.
REQ-013 SHALL hold a residue register (DATA_WIDTH data, count r, 0 <= r < KEEP_WIDTH) of bytes packed from LSB.
REQ-014 SHALL append accepted bytes at byte offset r: merged = residue | (tdata << 8r), total = r + n.
REQ-015 SHALL use a 2-state FSM, ACCUM and FLUSH.
REQ-016 ACCUM, no tlast, total < KEEP_WIDTH: SHALL update the residue only, with no output.
REQ-017 ACCUM, no tlast, total >= KEEP_WIDTH: SHALL load the output register with the low KEEP_WIDTH bytes (tkeep all ones, tlast 0) and set the residue to the upper total-KEEP_WIDTH bytes.
REQ-018 ACCUM, tlast, total <= KEEP_WIDTH: SHALL emit merged with tkeep = (1<<total)-1 and tlast 1, then clear the residue.
REQ-019 ACCUM, tlast, total > KEEP_WIDTH: SHALL emit the full low beat with tlast 0, keep the overflow bytes as residue and go to FLUSH.
REQ-020 FLUSH: SHALL deassert s_axis_tready; when the output register frees, SHALL emit the residue with tkeep = (1<<r)-1 and tlast 1, clear the residue and return to ACCUM.
REQ-021 Zero-byte tlast beat with r = 0: SHALL emit one beat with tkeep 0 and tlast 1, so every packet terminates with tlast.
REQ-022 Zero-byte beat without tlast: SHALL be accepted with no state change.
REQ-023 s_axis_tready SHALL equal (state == ACCUM) && (!m_axis_tvalid || m_axis_tready).
REQ-024 Output register SHALL hold all m_axis_* fields stable while m_axis_tvalid && !m_axis_tready; a new beat loads in the same cycle the current one is taken.
REQ-025 Latency SHALL be 1 cycle from the accepting input edge to m_axis_tvalid; full throughput when no FLUSH occurs.
REQ-026 SHALL capture tuser from the first accepted beat of each packet and present it on the first output beat only; later beats carry tuser 0.
REQ-027 SHALL leave output tdata bytes beyond tkeep as zero.

Reset
REQ-028 While axis_resetn = 0 at a clock edge, the block SHALL go to ACCUM with r = 0, residue 0, m_axis_tvalid/tlast 0, m_axis_tdata/tkeep/tuser 0, keep_err 0 and s_axis_tready 0.
REQ-029 Reset mid-packet SHALL discard the residue and any held output beat; the first beat after reset is treated as the start of a packet.

Structure
REQ-030 SHALL keep the byte-count-to-keep-mask function and the FSM state encoding in shared package axis_pkg.
REQ-031 SHALL place the combinational residue/beat merge (shift, OR, overflow split) in a single sub-module, byte_merge; FSM, residue and output register stay in axis_byte_packer.

Verification (DATA_WIDTH = 256)
REQ-032 Beats of 20 B, 20 B, then 10 B with tlast, m_axis_tready = 1 -> output 32 B (tlast 0), then 18 B (tkeep 0x3FFFF, tlast 1).
REQ-033 One 32 B tlast beat, with tuser 0xAB -> single output beat, tkeep all ones, tlast 1, tuser 0xAB, 1 cycle after accept.
REQ-034 30 B then 30 B with tlast -> 32 B (tlast 0), s_axis_tready low 1 cycle (FLUSH), then 28 B with tlast 1.
REQ-035 32 B (no tlast) then a 0-byte tlast beat -> 32 B (tlast 0), then tkeep 0 with tlast 1.
REQ-036 m_axis_tready toggling randomly over 100 random packets -> byte-exact match with a reference model, no beat loss or duplication, stable outputs during stalls.
REQ-037 tkeep 0x5 accepted -> keep_err = 1 and 1 byte counted; axis_resetn low mid-packet -> all outputs 0 and residue dropped.

Source files
------------

// File: rtl/axis_pkg.sv
// Shared definitions for the AXIS byte packer: FSM encoding and the
// byte-count to tkeep-mask helper.
package axis_pkg;

    // Widest tkeep the helper supports (tdata up to 1024 bits).
    localparam int unsigned KEEP_MAX = 128;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } state_t;

    // Returns a mask with the low cnt bits set; callers size-cast it to their tkeep width.
    function automatic logic [KEEP_MAX-1:0] count_to_keep(input int unsigned cnt);
        logic [KEEP_MAX-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < KEEP_MAX; i++) begin
            if (i < cnt) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/byte_merge.sv
// Combinational merge of an incoming sparse beat onto the residue bytes:
// byte count, masking, shift/OR and split into low beat and overflow.
module byte_merge
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int CW         = $clog2(KEEP_WIDTH + 1)
) (
    input  logic [DATA_WIDTH-1:0] residue,
    input  logic [CW-1:0]         res_cnt,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [KEEP_WIDTH-1:0] in_keep,
    output logic [CW-1:0]         in_cnt,
    output logic [CW:0]           total,
    output logic                  keep_gap,
    output logic [DATA_WIDTH-1:0] low_data,
    output logic [DATA_WIDTH-1:0] high_data
);

    logic [KEEP_WIDTH-1:0]   valid_keep;
    logic [DATA_WIDTH-1:0]   in_masked;
    logic [2*DATA_WIDTH-1:0] merged;

    // Byte count is the position of the lowest cleared tkeep bit.
    always_comb begin
        in_cnt = CW'(KEEP_WIDTH);
        for (int i = KEEP_WIDTH - 1; i >= 0; i--) begin
            if (!in_keep[i]) in_cnt = CW'(i);
        end
    end

    always_comb begin
        valid_keep = KEEP_WIDTH'(count_to_keep(32'(in_cnt)));
        in_masked  = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (valid_keep[i]) in_masked[8*i +: 8] = in_data[8*i +: 8];
        end
    end

    assign keep_gap  = |(in_keep & ~valid_keep);
    assign merged    = {{DATA_WIDTH{1'b0}}, residue}
                     | ({{DATA_WIDTH{1'b0}}, in_masked} << {res_cnt, 3'b000});
    assign total     = {1'b0, res_cnt} + {1'b0, in_cnt};
    assign low_data  = merged[DATA_WIDTH-1:0];
    assign high_data = merged[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: rtl/axis_byte_packer.sv
// Packs a sparse AXI-Stream (contiguous-from-LSB tkeep) into full beats,
// carrying leftover bytes across beats and flushing them at tlast.
module axis_byte_packer
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int TUSER_WIDTH = 128
) (
    input  logic                    axis_aclk,
    input  logic                    axis_resetn,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    keep_err
);

    localparam int KEEP_WIDTH = DATA_WIDTH / 8;
    localparam int CW         = $clog2(KEEP_WIDTH + 1);
    localparam logic [CW:0] KW_CNT = (CW+1)'(KEEP_WIDTH);

    state_t                  state, state_next;
    logic [DATA_WIDTH-1:0]   residue, residue_next;
    logic [CW-1:0]           res_cnt, res_cnt_next;
    logic                    sop, sop_next;
    logic                    user_pend, pend_next;
    logic [TUSER_WIDTH-1:0]  tuser_hold, hold_next;
    logic                    err_next;

    logic                    load, ld_last;
    logic [DATA_WIDTH-1:0]   ld_data;
    logic [KEEP_WIDTH-1:0]   ld_keep;
    logic [TUSER_WIDTH-1:0]  ld_user, eff_user;

    logic [CW-1:0]           in_cnt;
    logic [CW:0]             total;
    logic                    keep_gap, accept, out_free, first;
    logic [DATA_WIDTH-1:0]   low_data, high_data;

    byte_merge #(
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH),
        .CW         (CW)
    ) u_merge (
        .residue   (residue),
        .res_cnt   (res_cnt),
        .in_data   (s_axis_tdata),
        .in_keep   (s_axis_tkeep),
        .in_cnt    (in_cnt),
        .total     (total),
        .keep_gap  (keep_gap),
        .low_data  (low_data),
        .high_data (high_data)
    );

    // A beat moves on a rising edge where valid and ready are both high; a
    // producer holds its payload steady while valid is high and ready is low.
    assign out_free      = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = axis_resetn && (state == ACCUM) && out_free;
    assign accept        = s_axis_tvalid && s_axis_tready;
    // tuser belongs to the first output beat, which may come from a later input beat.
    assign first         = sop || user_pend;
    assign eff_user      = sop ? s_axis_tuser : tuser_hold;

    always_comb begin
        state_next   = state;
        residue_next = residue;
        res_cnt_next = res_cnt;
        sop_next     = sop;
        pend_next    = user_pend;
        hold_next    = tuser_hold;
        err_next     = keep_err | (accept & keep_gap);
        load         = 1'b0;
        ld_data      = '0;
        ld_keep      = '0;
        ld_last      = 1'b0;
        ld_user      = '0;
        case (state)
            ACCUM: begin
                if (accept && (in_cnt != '0 || s_axis_tlast)) begin
                    sop_next = s_axis_tlast;
                    if (sop) hold_next = s_axis_tuser;
                    ld_user = first ? eff_user : '0;
                    ld_data = low_data;
                    if (!s_axis_tlast && total < KW_CNT) begin
                        residue_next = low_data;
                        res_cnt_next = CW'(total);
                        pend_next    = first;
                    end else if (!s_axis_tlast || total > KW_CNT) begin
                        load         = 1'b1;
                        ld_keep      = '1;
                        residue_next = high_data;
                        res_cnt_next = CW'(total - KW_CNT);
                        pend_next    = 1'b0;
                        state_next   = s_axis_tlast ? FLUSH : ACCUM;
                    end else begin
                        load         = 1'b1;
                        ld_keep      = KEEP_WIDTH'(count_to_keep(32'(total)));
                        ld_last      = 1'b1;
                        residue_next = '0;
                        res_cnt_next = '0;
                        pend_next    = 1'b0;
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    load         = 1'b1;
                    ld_data      = residue;
                    ld_keep      = KEEP_WIDTH'(count_to_keep(32'(res_cnt)));
                    ld_last      = 1'b1;
                    ld_user      = user_pend ? tuser_hold : '0;
                    residue_next = '0;
                    res_cnt_next = '0;
                    pend_next    = 1'b0;
                    state_next   = ACCUM;
                end
            end
            default: state_next = ACCUM;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_resetn) begin
            state         <= ACCUM;
            residue       <= '0;
            res_cnt       <= '0;
            sop           <= 1'b1;
            user_pend     <= 1'b0;
            tuser_hold    <= '0;
            keep_err      <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
        end else begin
            state      <= state_next;
            residue    <= residue_next;
            res_cnt    <= res_cnt_next;
            sop        <= sop_next;
            user_pend  <= pend_next;
            tuser_hold <= hold_next;
            keep_err   <= err_next;
            if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= ld_data;
                m_axis_tkeep  <= ld_keep;
                m_axis_tuser  <= ld_user;
                m_axis_tlast  <= ld_last;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end

endmodule
